alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Shares the bus-attached accumulator ALU between two requesters. Round-robin arbitration.
//  Runs each accepted operation as a fixed bus sequence: load B, apply op with A, read back.
//  Returns result = A <op> B on a valid/ready response channel.
//  Sits between the ALU (alu_wr/alu_rd/alu_op, shared 32-bit tristate bus) and the core's
//  execute-stage requesters.
// PARAMETERS
//  DATA_W  32  operand/result/bus width
//  OP_W    5   ALU opcode width
// PORTS
//  clk         in     1       clock, all state on posedge
//  rst_n       in     1       asynchronous active-low reset
//  req0_valid  in     1       requester 0 has an operation
//  req0_ready  out    1       requester 0 operation accepted this cycle
//  req0_op     in     OP_W    requester 0 ALU opcode
//  req0_a      in     DATA_W  requester 0 operand A
//  req0_b      in     DATA_W  requester 0 operand B
//  req1_*      same set as req0_*, for requester 1
//  rsp_valid   out    1       response available
//  rsp_ready   in     1       consumer takes response
//  rsp_id      out    1       index of the requester the response belongs to
//  rsp_result  out    DATA_W  ALU result
//  rsp_err     out    1       opcode was illegal; pass-through (00000) was executed instead
//  alu_wr      out    1       ALU accumulator write strobe
//  alu_rd      out    1       ALU drives bus with accumulator
//  alu_op      out    OP_W    ALU opcode
//  bus         inout  DATA_W  shared ALU bus; driven here only in LOAD_B/LOAD_A, else 'z
//  busy        out    1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to IDLE. All outputs are 0; bus is released ('z).
//   - rsp_* are cleared and last_grant=1, so port 0 wins first.
//   - Reset mid-sequence aborts the operation; no response is produced.
//   - ALU acc content after reset is don't-care; LOAD_B always rewrites it.
//  FSM: IDLE -> LOAD_B -> LOAD_A -> READ -> RESP -> IDLE.
//   - alu_*, bus_oe and reqN_ready are decoded combinationally from the state register.
//  IDLE
//   - If any reqN_valid, grant one port and assert its reqN_ready in the same cycle.
//   - Latch op/a/b/id on the posedge, then go to LOAD_B.
//   - Only one ready per cycle. No ready outside IDLE.
//  Arbitration
//   - Only one valid: grant it.
//   - Both valid: grant the port != last_grant, then update last_grant.
//  Opcodes
//   - Legal: 00000, 10000, 11000, 10001, 10010, 10011, 10100, 10101, 11101, 10110, 10111.
//   - Any other opcode: latch 00000 and set err=1.
//  LOAD_B: bus=b, alu_op=00000, alu_wr=1, so acc<=b.
//  LOAD_A: bus=a, alu_op=op, alu_wr=1, so acc<=a op b.
//   - Shift amount is b[4:0]. Compares are unsigned. Wrap mod 2^DATA_W.
//  READ: alu_rd=1, sequencer bus driver off, rsp_result<=bus on the posedge.
//  RESP
//   - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
//   - rsp_valid && rsp_ready: go to IDLE and clear rsp_valid.
//   - New requests are not accepted in RESP.
//  Invariants
//   - Never drive bus and assert alu_rd in the same cycle.
//   - alu_wr=0 and alu_rd=0 outside their states.
//  Latency: accept at cycle T; rsp_valid at T+4. Max throughput 1 op / 5 cycles.
// TESTING
//  1. req0 op=11000, a=5, b=3 -> req0_ready@T; bus=3@T+1, bus=5@T+2; rsp_result=2, rsp_id=0@T+4.
//  2. req1 op=10001, a=1, b=35 -> rsp_result=8 (shift uses b[4:0]=3), rsp_err=0.
//  3. req0 and req1 both valid from reset, ops 10000 (1+2) and 10111 (F0&3C) ->
//     port0 served first (3), then port1 (30); then port0 again if still valid.
//  4. rsp_ready held low 3 cycles in RESP -> rsp_valid and rsp_result stable; no reqN_ready.
//  5. op=01111, a=0xABCD -> rsp_err=1, rsp_result=0xABCD, alu_op=00000 in LOAD_A.
//  6. rst_n low during LOAD_A -> immediate IDLE, bus 'z, alu_wr=0, no response;
//     next request completes correctly.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module   : alu_sequencer_if
// Brief    : Request/response handshake bundle between the execute-stage
//            requesters and the ALU sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        input  rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Round-robin sharing of a bus-attached accumulator ALU between two
//            requesters; runs load-B / op-with-A / read-back per operation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  wire                clk,
    input  wire                rst_n,
    alu_sequencer_if.slave     rif,
    output logic               alu_wr,
    output logic               alu_rd,
    output logic [OP_W-1:0]    alu_op,
    inout  wire  [DATA_W-1:0]  bus,
    output logic               busy
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load_b = 3'd1;
    localparam logic [2:0] c_st_load_a = 3'd2;
    localparam logic [2:0] c_st_read   = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    logic [2:0]        r_state;
    logic              r_last_grant;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;
    logic              r_err;
    logic [DATA_W-1:0] r_result;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [OP_W-1:0]   w_sel_op;
    logic              w_sel_legal;
    logic              w_bus_oe;
    logic [DATA_W-1:0] w_bus_drv;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            5'b00000, 5'b10000, 5'b11000, 5'b10001, 5'b10010, 5'b10011,
            5'b10100, 5'b10101, 5'b11101, 5'b10110, 5'b10111: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // On contention the port that did not win last time gets the grant.
    assign w_idle      = (r_state == c_st_idle);
    assign w_gnt0      = rif.req0_valid && (!rif.req1_valid || r_last_grant);
    assign w_gnt1      = rif.req1_valid && (!rif.req0_valid || !r_last_grant);
    assign w_sel_op    = w_gnt1 ? rif.req1_op : rif.req0_op;
    assign w_sel_legal = op_legal(w_sel_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
            r_result     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_op         <= w_sel_legal ? w_sel_op : '0;
                        r_err        <= !w_sel_legal;
                        r_a          <= w_gnt1 ? rif.req1_a : rif.req0_a;
                        r_b          <= w_gnt1 ? rif.req1_b : rif.req0_b;
                        r_state      <= c_st_load_b;
                    end
                end
                c_st_load_b: r_state <= c_st_load_a;
                c_st_load_a: r_state <= c_st_read;
                c_st_read: begin
                    r_result <= bus;
                    r_state  <= c_st_resp;
                end
                c_st_resp: begin
                    if (rif.rsp_ready) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Bus driver and alu_rd come from disjoint states, so they never overlap.
    always_comb begin
        alu_wr    = 1'b0;
        alu_rd    = 1'b0;
        alu_op    = '0;
        w_bus_oe  = 1'b0;
        w_bus_drv = r_b;
        case (r_state)
            c_st_load_b: begin
                alu_wr   = 1'b1;
                w_bus_oe = 1'b1;
            end
            c_st_load_a: begin
                alu_wr    = 1'b1;
                alu_op    = r_op;
                w_bus_oe  = 1'b1;
                w_bus_drv = r_a;
            end
            c_st_read: alu_rd = 1'b1;
            default: ;
        endcase
    end

    assign bus            = w_bus_oe ? w_bus_drv : {DATA_W{1'bz}};
    assign busy           = !w_idle;
    assign rif.req0_ready = rst_n && w_idle && w_gnt0;
    assign rif.req1_ready = rst_n && w_idle && w_gnt1;
    assign rif.rsp_valid  = (r_state == c_st_resp);
    assign rif.rsp_id     = r_id;
    assign rif.rsp_err    = r_err;
    assign rif.rsp_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer with an ALU model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        alu_wr;
    logic        alu_rd;
    logic [4:0]  alu_op;
    wire  [31:0] bus;
    logic        busy;
    logic [31:0] r_acc;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer_if #(.DATA_W(32), .OP_W(5)) rif ();

    alu_sequencer #(.DATA_W(32), .OP_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rif    (rif),
        .alu_wr (alu_wr),
        .alu_rd (alu_rd),
        .alu_op (alu_op),
        .bus    (bus),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator ALU: acc <= bus op acc on a write strobe, drives acc on read.
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] x, input logic [31:0] acc);
        case (op)
            5'b10000: return x + acc;
            5'b11000: return x - acc;
            5'b10001: return x << acc[4:0];
            5'b10111: return x & acc;
            default:  return x;
        endcase
    endfunction

    always @(posedge clk) if (alu_wr) r_acc <= alu_f(alu_op, bus, r_acc);
    assign bus = alu_rd ? r_acc : 32'hzzzz_zzzz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bus_released();
        return (bus === 32'hzzzz_zzzz) || (bus === 32'h0);
    endfunction

    task automatic run_op(input logic port, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input logic [4:0] exp_aluop);
        @(negedge clk);
        if (port) begin
            rif.req1_valid = 1'b1; rif.req1_op = op; rif.req1_a = a; rif.req1_b = b;
        end else begin
            rif.req0_valid = 1'b1; rif.req0_op = op; rif.req0_a = a; rif.req0_b = b;
        end
        #1;
        chk("accept_ready", {rif.req1_ready, rif.req0_ready}, port ? 2'b10 : 2'b01);
        @(negedge clk);
        rif.req0_valid = 1'b0;
        rif.req1_valid = 1'b0;
        chk("load_b_bus", bus, b);
        chk("load_b_ctl", {alu_wr, alu_rd, alu_op, rif.req1_ready, rif.req0_ready}, {2'b10, 5'b0, 2'b00});
        @(negedge clk);
        chk("load_a_bus", bus, a);
        chk("load_a_ctl", {alu_wr, alu_rd, alu_op}, {2'b10, exp_aluop});
        @(negedge clk);
        chk("read_ctl", {alu_wr, alu_rd, rif.rsp_valid, busy}, 4'b0101);
        @(negedge clk);
        chk("rsp", {rif.rsp_valid, rif.rsp_id, rif.rsp_err, rif.rsp_result}, {1'b1, port, exp_err, exp_res});
        rif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("back_idle", {rif.rsp_valid, busy}, 2'b00);
        rif.rsp_ready = 1'b0;
    endtask

    initial begin
        logic saw_rsp;
        rst_n = 1'b0;
        rif.rsp_ready  = 1'b0;
        rif.req0_valid = 1'b1; rif.req0_op = 5'b0; rif.req0_a = 32'h0; rif.req0_b = 32'h0;
        rif.req1_valid = 1'b0; rif.req1_op = 5'b0; rif.req1_a = 32'h0; rif.req1_b = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state: everything quiet, no ready even with a valid request.
        chk("rst_ctl", {alu_wr, alu_rd, alu_op, busy, rif.rsp_valid, rif.rsp_err, rif.rsp_id}, 11'b0);
        chk("rst_result", rif.rsp_result, 32'h0);
        chk("rst_ready", {rif.req1_ready, rif.req0_ready}, 2'b00);
        chk("rst_bus", bus_released(), 1'b1);
        rif.req0_valid = 1'b0;
        rst_n = 1'b1;

        // Subtract, then shift using only b[4:0].
        run_op(1'b0, 5'b11000, 32'd5, 32'd3, 32'd2, 1'b0, 5'b11000);
        run_op(1'b1, 5'b10001, 32'd1, 32'd35, 32'd8, 1'b0, 5'b10001);

        // Contention from reset, with a stalled response.
        @(negedge clk);
        rst_n = 1'b0;
        rif.req0_valid = 1'b1; rif.req0_op = 5'b10000; rif.req0_a = 32'h1;  rif.req0_b = 32'h2;
        rif.req1_valid = 1'b1; rif.req1_op = 5'b10111; rif.req1_a = 32'hF0; rif.req1_b = 32'h3C;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arb_first", {rif.req1_ready, rif.req0_ready}, 2'b01);
        repeat (4) @(negedge clk);
        chk("arb_rsp0", {rif.rsp_valid, rif.rsp_id, rif.rsp_err, rif.rsp_result}, {3'b100, 32'd3});
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_ready", {rif.req1_ready, rif.req0_ready}, 2'b00);
            chk("stall_hold", {rif.rsp_valid, rif.rsp_id, rif.rsp_result}, {2'b10, 32'd3});
            if (i < 2) @(negedge clk);
        end
        rif.rsp_ready = 1'b1;
        @(negedge clk);
        rif.rsp_ready = 1'b0;
        chk("arb_second", {rif.req1_ready, rif.req0_ready, rif.rsp_valid}, 3'b100);
        repeat (4) @(negedge clk);
        chk("arb_rsp1", {rif.rsp_valid, rif.rsp_id, rif.rsp_err, rif.rsp_result}, {3'b110, 32'h30});
        rif.rsp_ready = 1'b1;
        @(negedge clk);
        rif.rsp_ready = 1'b0;
        chk("arb_third", {rif.req1_ready, rif.req0_ready}, 2'b01);
        rif.req0_valid = 1'b0;
        rif.req1_valid = 1'b0;

        // Illegal opcode degrades to pass-through of A.
        run_op(1'b0, 5'b01111, 32'hABCD, 32'h7, 32'hABCD, 1'b1, 5'b00000);

        // Reset during LOAD_A aborts without a response.
        @(negedge clk);
        rif.req0_valid = 1'b1; rif.req0_op = 5'b10000; rif.req0_a = 32'h7; rif.req0_b = 32'h9;
        #1;
        chk("abort_accept", rif.req0_ready, 1'b1);
        @(negedge clk);
        rif.req0_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_load_a", {alu_wr, bus}, {1'b1, 32'h7});
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", {alu_wr, alu_rd, busy, rif.rsp_valid}, 4'b0000);
        chk("abort_bus", bus_released(), 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rif.rsp_valid) saw_rsp = 1'b1;
        end
        chk("abort_no_rsp", saw_rsp, 1'b0);
        run_op(1'b1, 5'b10000, 32'd10, 32'd20, 32'd30, 1'b0, 5'b10000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
